// File: rtl/div_seq_if.sv
// Handshake bundle between the execute stage (master) and the iterative
// divider (slave).
//
// Handshake: the master raises start with the operands valid and holds start,
// signed_div and the operands steady until ready is seen high. ready then
// stays high with result stable for as long as start stays high. Dropping
// start, or raising annul, releases the divider. annul may be raised at any
// time to abandon a pending or running division. state is a read-only view of
// the divider FSM for debug and checkers.
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic                  start;
  logic                  annul;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic [1:0]            state;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, state
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, state
  );
endinterface

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU. A division produces one quotient
// bit per cycle, MSB first. The result is {remainder, quotient}, with the
// quotient truncated toward zero and the remainder taking the dividend's sign.
// The FSM encoding (FREE=0, BYZERO=1, ON=2, END=3) is visible on bus.state.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Upper half holds the partial remainder. The lower half starts as the
  // dividend magnitude and fills with quotient bits as the dividend shifts out.
  logic [2*DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  signed_q, signed_d;
  logic                  sign1_q, sign1_d;
  logic                  sign2_q, sign2_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W:0]       shifted;
  logic [DATA_W-1:0]     diff;
  logic                  no_borrow;
  logic [DATA_W-1:0]     quot_fix;
  logic [DATA_W-1:0]     rem_fix;
  logic [DATA_W-1:0]     abs1;
  logic [DATA_W-1:0]     abs2;

  // Datapath for one restoring step plus the sign correction of the final result.
  always_comb begin
    shifted   = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
    no_borrow = (shifted >= {1'b0, divisor_q});
    // When there is no borrow the difference is below the divisor, so it fits in DATA_W bits.
    diff      = shifted[DATA_W-1:0] - divisor_q;
    quot_fix  = (signed_q && (sign1_q ^ sign2_q)) ? (DATA_W'(0) - work_q[DATA_W-1:0])
                                                  : work_q[DATA_W-1:0];
    rem_fix   = (signed_q && sign1_q) ? (DATA_W'(0) - work_q[2*DATA_W-1:DATA_W])
                                      : work_q[2*DATA_W-1:DATA_W];
    abs1      = (bus.signed_div && bus.opdata1[DATA_W-1]) ? (DATA_W'(0) - bus.opdata1)
                                                          : bus.opdata1;
    abs2      = (bus.signed_div && bus.opdata2[DATA_W-1]) ? (DATA_W'(0) - bus.opdata2)
                                                          : bus.opdata2;
  end

  // Next-state logic and next values of all working and output registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start && !bus.annul) begin
          signed_d  = bus.signed_div;
          sign1_d   = bus.opdata1[DATA_W-1];
          sign2_d   = bus.opdata2[DATA_W-1];
          work_d    = {{DATA_W{1'b0}}, abs1};
          divisor_d = abs2;
          cnt_d     = '0;
          state_d   = (bus.opdata2 == '0) ? S_BYZERO : S_ON;
        end
      end

      S_BYZERO: begin
        // Divide-by-zero reports two edges after the request: one edge in
        // BYZERO with cnt 0, then on to END.
        if (bus.annul) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end

      S_ON: begin
        if (bus.annul) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          state_d  = S_END;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end else begin
          work_d = {(no_borrow ? diff : shifted[DATA_W-1:0]),
                    work_q[DATA_W-2:0], no_borrow};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      S_END: begin
        if (!bus.start || bus.annul) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = S_FREE;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State and working registers; reset abandons any division at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a table of hand-computed divisions plus
// sequences for annulment, ignored requests and asynchronous reset.
module tb_div_seq;

  localparam int LAT_MAX = 100;
  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_END  = 2'd3;

  logic clk;
  logic rst;

  div_seq_if #(.DATA_W(32)) bus ();

  div_seq #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int errors;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    bit          scramble;
    string       name;
  } vec_t;

  vec_t vecs[13];

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Entered at a negedge; leaves at a negedge with the divider back in FREE.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat, input bit scramble,
                         input string name);
    int lat;
    bit got;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    bus.annul      = 1'b0;
    @(posedge clk);
    lat = 0;
    got = 0;
    while (!got && lat < LAT_MAX) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.ready) got = 1;
      if (scramble && lat == 5) begin
        bus.opdata1    = $urandom_range(32'hFFFF_FFFF, 0);
        bus.opdata2    = $urandom_range(32'hFFFF_FFFF, 0);
        bus.signed_div = ~sgn;
      end
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, bus.result, exp);
    check({name, " state_end"}, 64'(bus.state), 64'(ST_END));
    @(posedge clk);
    @(negedge clk);
    check({name, " hold_ready"}, 64'(bus.ready), 64'd1);
    check({name, " hold_result"}, bus.result, exp);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, " drop_ready"}, 64'(bus.ready), 64'd0);
    check({name, " drop_result"}, bus.result, 64'd0);
    check({name, " drop_state"}, 64'(bus.state), 64'(ST_FREE));
  endtask

  initial begin
    bit saw;
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 1'b0, "u_100_7"};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 1'b0, "s_m7_2"};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC, 33, 1'b0, "u_fff9_2"};
    vecs[3]  = '{1'b1, 32'd1234,       32'd0,          64'h00000000_00000000, 2,  1'b0, "s_div0"};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 33, 1'b0, "s_ovf"};
    vecs[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 33, 1'b0, "u_ovf_ops"};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 33, 1'b0, "u_max_1"};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 33, 1'b0, "s_7_m2"};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E, 33, 1'b0, "s_m100_m7"};
    vecs[9]  = '{1'b0, 32'd5,          32'd10,         64'h00000005_00000000, 33, 1'b0, "u_5_10"};
    vecs[10] = '{1'b0, 32'd0,          32'd0,          64'h00000000_00000000, 2,  1'b0, "u_div0"};
    vecs[11] = '{1'b0, 32'd50,         32'd5,          64'h00000000_0000000A, 33, 1'b0, "u_50_5"};
    vecs[12] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 1'b1, "u_100_7_scramble"};

    // reset
    rst            = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_result", bus.result, 64'd0);
    check("reset_state", 64'(bus.state), 64'(ST_FREE));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_ready", 64'(bus.ready), 64'd0);

    // table-driven divisions, back to back
    for (int i = 0; i < 13; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
              vecs[i].scramble, vecs[i].name);
    end

    // annul after 10 iterations, then an immediate new division
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    @(posedge clk);
    saw = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready) saw = 1;
    end
    bus.annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul_state", 64'(bus.state), 64'(ST_FREE));
    check("annul_ready", 64'(bus.ready | saw), 64'd0);
    check("annul_result", bus.result, 64'd0);
    run_div(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33, 1'b0, "annul_restart");

    // annul while in BYZERO
    bus.signed_div = 1'b1;
    bus.opdata1    = 32'd5;
    bus.opdata2    = 32'd0;
    bus.start      = 1'b1;
    bus.annul      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.annul = 1'b1;
    saw = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready) saw = 1;
    end
    check("byzero_annul_state", 64'(bus.state), 64'(ST_FREE));
    check("byzero_annul_ready", 64'(saw), 64'd0);

    // start and annul together in FREE: ignored
    bus.opdata2 = 32'd7;
    saw = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready || bus.state != ST_FREE) saw = 1;
    end
    check("start_annul_ignored", 64'(saw), 64'd0);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    // asynchronous reset at iteration 20
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd7;
    bus.start      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_state", 64'(bus.state), 64'(ST_FREE));
    check("rst_mid_ready", 64'(bus.ready), 64'd0);
    check("rst_mid_result", bus.result, 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready) saw = 1;
    end
    check("rst_no_spurious_ready", 64'(saw), 64'd0);

    // asynchronous reset while a result is being held
    bus.opdata1 = 32'd100;
    bus.opdata2 = 32'd7;
    bus.start   = 1'b1;
    @(posedge clk);
    saw = 0;
    for (int n = 0; n < LAT_MAX && !saw; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready) saw = 1;
    end
    check("rst_end_pre_result", bus.result, 64'h00000002_0000000E);
    #2 rst = 1'b1;
    #1;
    check("rst_end_ready", 64'(bus.ready), 64'd0);
    check("rst_end_result", bus.result, 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_end_after_state", 64'(bus.state), 64'(ST_FREE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
